// File: rtl/test_response_comparator.sv
// ---------------------------------------------------------------------------
// test_response_comparator
//
// Compares one test pattern's worth of array responses (NUM_ROW beats of
// NUM_COL column words) against golden data. Each beat's per-column mismatch
// vector is presented one cycle later on col_fault together with the beat
// index on row_idx, to feed the diagnostic loop chain. Beats with at least
// one faulty column are counted in fault_beats. If the response stream
// stalls for TIMEOUT consecutive cycles, the pattern is aborted and the
// sticky timeout_err flag is raised.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   test_start   one-cycle request to start a pattern (only honoured when idle)
//   pe_valid     response beat valid
//   pe_out       column responses, column c at [c*DATA_W +: DATA_W]
//   golden       expected responses, same packing as pe_out
//   col_fault    registered per-column mismatch strobes
//   row_idx      beat index reported alongside col_fault
//   busy         pattern in progress
//   done         one-cycle completion pulse (normal end or timeout)
//   timeout_err  sticky abort flag, cleared by the next accepted start
//   fault_beats  number of beats with any mismatch, saturating at NUM_ROW
// ---------------------------------------------------------------------------
module test_response_comparator #(
  parameter int NUM_COL = 8,
  parameter int NUM_ROW = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 32,
  localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
  localparam int FW = $clog2(NUM_ROW) + 1,
  localparam int IW = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      test_start,
  input  logic                      pe_valid,
  input  logic [NUM_COL*DATA_W-1:0] pe_out,
  input  logic [NUM_COL*DATA_W-1:0] golden,
  output logic [NUM_COL-1:0]        col_fault,
  output logic [RW-1:0]             row_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic [FW-1:0]             fault_beats
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BEAT = 2'd1,
    LAST      = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state, next_state;

  logic [RW-1:0]      beat_cnt;
  logic [IW-1:0]      idle_cnt;
  logic [NUM_COL-1:0] mismatch;
  logic               start_ok;
  logic               beat;
  logic               timeout_hit;

  // Per-column word compare, evaluated every cycle; only used on a beat.
  always_comb begin
    mismatch = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      mismatch[c] = (pe_out[c*DATA_W +: DATA_W] != golden[c*DATA_W +: DATA_W]);
    end
  end

  assign start_ok = (state == IDLE) && test_start;
  assign beat     = (state == WAIT_BEAT) && pe_valid;
  // The timeout fires on the idle cycle that would bring the counter to
  // TIMEOUT; a beat in that cycle is simply not an idle cycle, so it wins.
  assign timeout_hit = (state == WAIT_BEAT) && !pe_valid &&
                       (idle_cnt == IW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (test_start) next_state = WAIT_BEAT;
      WAIT_BEAT: begin
        if (beat && (beat_cnt == RW'(NUM_ROW - 1))) next_state = LAST;
        else if (timeout_hit)                        next_state = DONE;
      end
      LAST:      next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe and are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == WAIT_BEAT) || (next_state == LAST);
      done <= (next_state == DONE);
    end
  end

  // Strobe path: col_fault is a single-cycle echo of a beat's mismatches;
  // row_idx keeps the last reported index between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_fault <= '0;
      row_idx   <= '0;
    end else begin
      col_fault <= beat ? mismatch : '0;
      if (beat) row_idx <= beat_cnt;
    end
  end

  // Beat/idle counters plus the result registers that persist after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      fault_beats <= '0;
      timeout_err <= 1'b0;
    end else if (start_ok) begin
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      fault_beats <= '0;
      timeout_err <= 1'b0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 1'b1;
      idle_cnt <= '0;
      if ((|mismatch) && (fault_beats != FW'(NUM_ROW))) begin
        fault_beats <= fault_beats + 1'b1;
      end
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
      idle_cnt    <= '0;
    end else if (state == WAIT_BEAT) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: doc/test_response_comparator.md
TEST_RESPONSE_COMPARATOR -- requirements
Module: test_response_comparator

Interface
REQ-001 Parameter NUM_COL, default 8: number of array columns, i.e. fault strobe lanes.
REQ-002 Parameter NUM_ROW, default 8: response beats per test pattern, equal to the diagnostic loop depth.
REQ-003 Parameter DATA_W, default 16: width of one column response word.
REQ-004 Parameter TIMEOUT, default 32: maximum idle cycles between beats before abort.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port test_start  input  1  one-cycle request to begin one pattern comparison.
REQ-008 Port pe_valid  input  1  response beat valid.
REQ-009 Port pe_out  input  NUM_COL*DATA_W  column responses; column c occupies bits [c*DATA_W +: DATA_W].
REQ-010 Port golden  input  NUM_COL*DATA_W  expected responses with the same packing, sampled with pe_valid.
REQ-011 Port col_fault  output  NUM_COL  per-column fault strobes feeding the diagnostic loop chain column inputs.
REQ-012 Port row_idx  output  clog2(NUM_ROW)  index of the beat currently reported on col_fault.
REQ-013 Port busy  output  1  high from the accepted start until done.
REQ-014 Port done  output  1  one-cycle completion pulse.
REQ-015 Port timeout_err  output  1  sticky abort flag, held until the next accepted start.
REQ-016 Port fault_beats  output  clog2(NUM_ROW)+1  count of beats with at least one faulty column.

Function
REQ-017 FSM states shall be IDLE, WAIT_BEAT, LAST, DONE; the state shall be IDLE out of reset.
REQ-018 In IDLE, test_start=1 shall move the FSM to WAIT_BEAT, clear beat_cnt, fault_beats, timeout_err and the idle counter, and raise busy on the next cycle.
REQ-019 test_start shall be ignored in every state other than IDLE.
REQ-020 In WAIT_BEAT, each cycle with pe_valid=1 shall be one beat; compare each column word of pe_out with the same column of golden.
REQ-021 col_fault[c] shall be registered: high exactly one cycle after a beat whose column c mismatched, and 0 in all other cycles.
REQ-022 row_idx shall be registered alongside col_fault and shall carry that beat's index, 0..NUM_ROW-1.
REQ-023 A beat with any mismatch shall increment fault_beats by 1; the count saturates at NUM_ROW.
REQ-024 A beat with pe_valid=1 outside WAIT_BEAT shall be ignored: no strobe and no count change.
REQ-025 beat_cnt shall increment on each beat in WAIT_BEAT.
REQ-026 The beat with beat_cnt = NUM_ROW-1 shall move the FSM to LAST.
REQ-027 LAST shall last one cycle, during which the final strobe is presented; the FSM then moves to DONE.
REQ-028 DONE shall assert done for one cycle, deassert busy, and return the FSM to IDLE.
REQ-029 The idle counter shall increment in WAIT_BEAT on each cycle with pe_valid=0 and clear on each beat.
REQ-030 When the idle counter reaches TIMEOUT, the block shall set timeout_err and move the FSM to DONE without finishing the remaining beats.
REQ-031 fault_beats and timeout_err shall hold their values after DONE until the next accepted test_start.
REQ-032 If pe_valid=1 and the idle counter reaches TIMEOUT in the same cycle, the beat shall be taken and the timeout shall not fire.

Reset
REQ-033 rst_n=0 shall immediately force state=IDLE, col_fault=0, row_idx=0, busy=0, done=0, timeout_err=0 and fault_beats=0, and clear all internal counters.
REQ-034 A reset asserted mid-pattern shall abort the pattern with no done pulse; after release the block shall wait for a new test_start.

Verification
REQ-035 Start, then 8 consecutive beats with pe_out == golden -> col_fault=0 on all cycles, row_idx 0..7, done pulse one cycle after the LAST cycle, fault_beats=0.
REQ-036 Start, then 8 beats with column 3 mismatching on beat 5 only -> col_fault=8'h08 with row_idx=5 for exactly one cycle, fault_beats=1.
REQ-037 Start, then 8 beats with columns 0 and 7 mismatching on every beat -> col_fault=8'h81 on 8 cycles, fault_beats=8.
REQ-038 Start, then 3 beats, then pe_valid held 0 for 32 cycles -> timeout_err=1, done pulse, fault_beats reflecting beats 0..2, busy=0.
REQ-039 Assert test_start again on beat 4 of a running pattern -> ignored: the pattern completes after 8 beats with a single done pulse.
REQ-040 Assert rst_n=0 on beat 4 -> all outputs are 0 asynchronously; after release, pe_valid beats without a start produce no col_fault.
